// File: rtl/seq_alu.sv
// seq_alu: clocked ALU with a barrel shifter and an iterative shift-add multiplier.
//
// Ports:
//   Clk     - system clock, rising edge
//   Reset   - synchronous, active-high
//   Start   - launch operation (accepted only while Busy=0)
//   OP      - opcode, latched with Start
//   InputA  - operand A
//   InputB  - operand B; low SHW bits are the shift amount for shift ops
//   Out     - registered result, held until the next Done
//   Zero    - registered Out==0
//   Carry   - registered carry / no-borrow / shifted-out bit / product overflow
//   Neg     - registered Out MSB
//   Busy    - multiply in flight
//   Done    - one-cycle pulse when Out and flags update
//
// FSM states:
//   state | meaning
//   IDLE  | accept Start; single-cycle ops complete here
//   MULT  | WIDTH shift-add iterations; result written on the last one
//   DONE  | cycle in which the multiply Done is visible; accepts Start like IDLE

module seq_alu #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       OP,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    output logic [WIDTH-1:0] Out,
    output logic             Zero,
    output logic             Carry,
    output logic             Neg,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_LSH  = 4'd5;
    localparam logic [3:0] OP_RSH  = 4'd6;
    localparam logic [3:0] OP_ASR  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_MULH = 4'd9;
    localparam logic [3:0] OP_GEQ  = 4'd10;
    localparam logic [3:0] OP_EQ   = 4'd11;
    localparam logic [3:0] OP_NEQ  = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               mulh;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic [SHW-1:0]     s;
    logic [WIDTH:0]     sum, diff, lsh_t, rsh_t, asr_t;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mul_res;
    logic               mul_c;

    // Shifts run on a vector one bit wider than the operand so that the last
    // bit shifted out lands in the extra bit; s=0 leaves that bit at 0.
    always_comb begin
        s       = InputB[SHW-1:0];
        sum     = {1'b0, InputA} + {1'b0, InputB};
        diff    = {1'b0, InputA} - {1'b0, InputB};
        lsh_t   = {1'b0, InputA} << s;
        rsh_t   = {InputA, 1'b0} >> s;
        asr_t   = $signed({InputA, 1'b0}) >>> s;
        alu_res = '0;
        alu_c   = 1'b0;
        case (OP)
            OP_ADD: begin alu_res = sum[WIDTH-1:0];    alu_c = sum[WIDTH];   end
            OP_SUB: begin alu_res = diff[WIDTH-1:0];   alu_c = ~diff[WIDTH]; end
            OP_AND: alu_res = InputA & InputB;
            OP_OR:  alu_res = InputA | InputB;
            OP_XOR: alu_res = InputA ^ InputB;
            OP_LSH: begin alu_res = lsh_t[WIDTH-1:0];  alu_c = lsh_t[WIDTH]; end
            OP_RSH: begin alu_res = rsh_t[WIDTH:1];    alu_c = rsh_t[0];     end
            OP_ASR: begin alu_res = asr_t[WIDTH:1];    alu_c = asr_t[0];     end
            OP_GEQ: alu_res = {{(WIDTH-1){1'b0}}, (InputA >= InputB)};
            OP_EQ:  alu_res = {{(WIDTH-1){1'b0}}, (InputA == InputB)};
            OP_NEQ: alu_res = {{(WIDTH-1){1'b0}}, (InputA != InputB)};
            default: ;
        endcase
    end

    // The final iteration's accumulator value is written straight to Out so
    // that Done lands one cycle after the last Busy cycle.
    always_comb begin
        acc_nxt = mplier[0] ? (acc + mcand) : acc;
        mul_res = mulh ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
        mul_c   = |acc_nxt[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            Out    <= '0;
            Zero   <= 1'b0;
            Carry  <= 1'b0;
            Neg    <= 1'b0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            mulh   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    Done  <= 1'b0;
                    if (Start) begin
                        if (OP == OP_MUL || OP == OP_MULH) begin
                            mcand  <= {{WIDTH{1'b0}}, InputA};
                            mplier <= InputB;
                            acc    <= '0;
                            cnt    <= WIDTH[CW-1:0];
                            mulh   <= (OP == OP_MULH);
                            Busy   <= 1'b1;
                            state  <= MULT;
                        end else begin
                            Out   <= alu_res;
                            Carry <= alu_c;
                            Zero  <= (alu_res == '0);
                            Neg   <= alu_res[WIDTH-1];
                            Done  <= 1'b1;
                        end
                    end
                end
                MULT: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        Out   <= mul_res;
                        Carry <= mul_c;
                        Zero  <= (mul_res == '0);
                        Neg   <= mul_res[WIDTH-1];
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start8 = 1'b0, start16 = 1'b0;
    logic [3:0]  op = '0;
    logic [15:0] a = '0, b = '0;

    logic [7:0]  out8;
    logic [15:0] out16;
    logic        z8, c8, n8, busy8, done8;
    logic        z16, c16, n16, busy16, done16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(8)) dut8 (
        .Clk(clk), .Reset(reset), .Start(start8), .OP(op),
        .InputA(a[7:0]), .InputB(b[7:0]),
        .Out(out8), .Zero(z8), .Carry(c8), .Neg(n8), .Busy(busy8), .Done(done8)
    );

    seq_alu #(.WIDTH(16)) dut16 (
        .Clk(clk), .Reset(reset), .Start(start16), .OP(op),
        .InputA(a), .InputB(b),
        .Out(out16), .Zero(z16), .Carry(c16), .Neg(n16), .Busy(busy16), .Done(done16)
    );

    typedef struct {
        int          w;
        logic [3:0]  op;
        logic [15:0] a, b, out;
        logic        c, z, n;
        string       name;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic sample(input int w, output logic d, output logic [15:0] o,
                          output logic c, output logic z, output logic n, output logic bsy);
        if (w == 8) begin
            d = done8; o = {8'h00, out8}; c = c8; z = z8; n = n8; bsy = busy8;
        end else begin
            d = done16; o = out16; c = c16; z = z16; n = n16; bsy = busy16;
        end
    endtask

    // Reference: results straight from the opcode definitions using wide integers.
    function automatic void model(input int w, input logic [3:0] op_i,
                                  input logic [15:0] a_i, input logic [15:0] b_i,
                                  output logic [15:0] r, output logic c,
                                  output logic z, output logic n);
        longint unsigned av = 64'(a_i), bv = 64'(b_i);
        longint unsigned m  = (64'd1 << w) - 1;
        longint unsigned p  = av * bv;
        longint          sa;
        int              sh = int'(bv % 64'(w));
        longint unsigned v  = 0;
        c = 1'b0;
        case (op_i)
            4'd0:  begin v = av + bv; c = ((v >> w) & 1) != 0; end
            4'd1:  begin v = av - bv; c = (av >= bv); end
            4'd2:  v = av & bv;
            4'd3:  v = av | bv;
            4'd4:  v = av ^ bv;
            4'd5:  begin v = av << sh; c = (sh != 0) && (((av >> (w - sh)) & 1) != 0); end
            4'd6:  begin v = av >> sh; c = (sh != 0) && (((av >> (sh - 1)) & 1) != 0); end
            4'd7:  begin
                sa = ((av >> (w - 1)) & 1) != 0 ? longint'(av) - longint'(64'd1 << w) : longint'(av);
                v  = longint'(sa >>> sh);
                c  = (sh != 0) && (((av >> (sh - 1)) & 1) != 0);
            end
            4'd8:  begin v = p; c = (p >> w) != 0; end
            4'd9:  begin v = p >> w; c = (p >> w) != 0; end
            4'd10: v = (av >= bv) ? 1 : 0;
            4'd11: v = (av == bv) ? 1 : 0;
            4'd12: v = (av != bv) ? 1 : 0;
            default: v = 0;
        endcase
        r = 16'(v & m);
        z = (r == 16'h0);
        n = r[w-1];
    endfunction

    task automatic run_op(input int w, input logic [3:0] op_i, input logic [15:0] a_i,
                          input logic [15:0] b_i, input logic [15:0] e_out,
                          input logic e_c, input logic e_z, input logic e_n, input string name);
        int cyc, bc, e_lat;
        logic d, fc, fz, fn, bsy;
        logic [15:0] o;
        e_lat = (op_i == 4'd8 || op_i == 4'd9) ? w + 1 : 1;
        @(negedge clk);
        op = op_i; a = a_i; b = b_i;
        if (w == 8) start8 = 1'b1; else start16 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; start16 = 1'b0;
        cyc = 1; bc = 0;
        sample(w, d, o, fc, fz, fn, bsy);
        while (!d && cyc < 100) begin
            if (bsy) bc++;
            @(posedge clk); #1;
            cyc++;
            sample(w, d, o, fc, fz, fn, bsy);
        end
        chk({name, " done"}, 32'(d), 32'd1);
        chk({name, " latency"}, 32'(cyc), 32'(e_lat));
        chk({name, " busy_cycles"}, 32'(bc), 32'(e_lat - 1));
        chk({name, " out"}, 32'(o), 32'(e_out));
        chk({name, " carry"}, 32'(fc), 32'(e_c));
        chk({name, " zero"}, 32'(fz), 32'(e_z));
        chk({name, " neg"}, 32'(fn), 32'(e_n));
        @(posedge clk); #1;
        sample(w, d, o, fc, fz, fn, bsy);
        chk({name, " done_pulse"}, 32'(d), 32'd0);
        chk({name, " out_held"}, 32'(o), 32'(e_out));
    endtask

    initial begin
        logic d, fc, fz, fn, bsy;
        logic [15:0] o, r;
        logic rc, rz, rn;
        int ndone, dcyc;
        logic [15:0] dout;
        int w;
        logic [3:0] rop;
        logic [15:0] ra, rb, msk;

        vecs[0]  = '{8,  4'd0,  16'h00FF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, "add_ff_01"};
        vecs[1]  = '{8,  4'd1,  16'h0005, 16'h0007, 16'h00FE, 1'b0, 1'b0, 1'b1, "sub_5_7"};
        vecs[2]  = '{8,  4'd7,  16'h0080, 16'h0003, 16'h00F0, 1'b0, 1'b0, 1'b1, "asr_80_3"};
        vecs[3]  = '{8,  4'd7,  16'h0080, 16'h0008, 16'h0080, 1'b0, 1'b0, 1'b1, "asr_s0"};
        vecs[4]  = '{8,  4'd8,  16'd200,  16'd3,    16'h0058, 1'b1, 1'b0, 1'b0, "mul_200_3"};
        vecs[5]  = '{8,  4'd9,  16'd200,  16'd3,    16'h0002, 1'b1, 1'b0, 1'b0, "mulh_200_3"};
        vecs[6]  = '{8,  4'd8,  16'd13,   16'd11,   16'h008F, 1'b0, 1'b0, 1'b1, "mul_13_11"};
        vecs[7]  = '{8,  4'd5,  16'h0081, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0, "lsh_81_1"};
        vecs[8]  = '{8,  4'd6,  16'h0003, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, "rsh_3_1"};
        vecs[9]  = '{8,  4'd8,  16'h00FF, 16'h00FF, 16'h0001, 1'b1, 1'b0, 1'b0, "mul_ff_ff"};
        vecs[10] = '{8,  4'd15, 16'h0012, 16'h0034, 16'h0000, 1'b0, 1'b1, 1'b0, "op15"};
        vecs[11] = '{16, 4'd8,  16'd200,  16'd3,    16'h0258, 1'b0, 1'b0, 1'b0, "w16_mul_200_3"};
        vecs[12] = '{16, 4'd9,  16'd200,  16'd3,    16'h0000, 1'b0, 1'b1, 1'b0, "w16_mulh_200_3"};
        vecs[13] = '{16, 4'd8,  16'd13,   16'd11,   16'h008F, 1'b0, 1'b0, 1'b0, "w16_mul_13_11"};
        vecs[14] = '{16, 4'd8,  16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, "w16_mul_ffff"};
        vecs[15] = '{16, 4'd9,  16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0, 1'b1, "w16_mulh_ffff"};
        vecs[16] = '{16, 4'd7,  16'h8000, 16'h0003, 16'hF000, 1'b0, 1'b0, 1'b1, "w16_asr_3"};
        vecs[17] = '{16, 4'd7,  16'h8000, 16'h0010, 16'h8000, 1'b0, 1'b0, 1'b1, "w16_asr_s0"};

        // Reset held for two cycles; every output must read 0.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("rst8 outs", {out8, z8, c8, n8, busy8, done8}, 32'd0);
            chk("rst16 outs", {out16, z16, c16, n16, busy16, done16}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i])
            run_op(vecs[i].w, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].out,
                   vecs[i].c, vecs[i].z, vecs[i].n, vecs[i].name);

        // Start during a multiply is ignored, as are new operand values.
        @(negedge clk);
        op = 4'd8; a = 16'd200; b = 16'd3; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        ndone = 0; dcyc = 0; dout = '0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            sample(8, d, o, fc, fz, fn, bsy);
            if (d) begin ndone++; dcyc = cyc; dout = o; end
            if (cyc == 2) begin op = 4'd0; a = 16'd1; b = 16'd1; start8 = 1'b1; end
            if (cyc == 3) start8 = 1'b0;
            @(posedge clk); #1;
        end
        chk("ignore_start done_count", 32'(ndone), 32'd1);
        chk("ignore_start done_cycle", 32'(dcyc), 32'd9);
        chk("ignore_start out", 32'(dout), 32'h58);

        // Reset in the middle of a multiply aborts it.
        run_op(8, 4'd0, 16'd1, 16'd1, 16'd2, 1'b0, 1'b0, 1'b0, "add_1_1");
        @(negedge clk);
        op = 4'd8; a = 16'd200; b = 16'd3; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("abort outs", {out8, z8, c8, n8, busy8, done8}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(posedge clk); #1;
            if (done8 || busy8) ndone++;
        end
        chk("abort no_done", 32'(ndone), 32'd0);
        chk("abort out_kept", 32'(out8), 32'd0);
        run_op(8, 4'd0, 16'd3, 16'd4, 16'd7, 1'b0, 1'b0, 1'b0, "post_abort_add");

        // Back-to-back single-cycle ops: OR, EQ, opcode 14.
        @(negedge clk);
        op = 4'd3; a = 16'h0C; b = 16'h03; start8 = 1'b1;
        @(posedge clk); #1;
        chk("b2b or done", 32'(done8), 32'd1);
        chk("b2b or out", 32'(out8), 32'h0F);
        op = 4'd11; a = 16'd5; b = 16'd5;
        @(posedge clk); #1;
        chk("b2b eq done", 32'(done8), 32'd1);
        chk("b2b eq out", 32'(out8), 32'h01);
        op = 4'd14; a = 16'h55; b = 16'h0F;
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("b2b op14 done", 32'(done8), 32'd1);
        chk("b2b op14 out", 32'(out8), 32'h00);
        chk("b2b op14 zero", 32'(z8), 32'd1);
        @(posedge clk); #1;
        chk("b2b end done", 32'(done8), 32'd0);

        // Random ops at both widths against the reference model.
        for (int k = 0; k < 240; k++) begin
            w   = (k % 2 == 0) ? 8 : 16;
            msk = (w == 8) ? 16'h00FF : 16'hFFFF;
            rop = 4'($urandom_range(0, 15));
            ra  = 16'($urandom) & msk;
            rb  = 16'($urandom) & msk;
            model(w, rop, ra, rb, r, rc, rz, rn);
            run_op(w, rop, ra, rb, r, rc, rz, rn, $sformatf("rand w%0d op%0d a%0h b%0h", w, rop, ra, rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
